// File: rtl/accum_writeback_drain_if.sv
// Write-back read port of the accumulation buffer plus the ofmap output stream.
// master = drain engine, slave = buffer/stream side.
interface accum_writeback_drain_if #(
    parameter int DATA_WIDTH      = 64,
    parameter int BANK_ADDR_WIDTH = 7
);
    logic                       ren_wb;
    logic [BANK_ADDR_WIDTH-1:0] radr_wb;
    logic [DATA_WIDTH-1:0]      rdata_wb;
    logic [DATA_WIDTH-1:0]      ofmap_data;
    logic                       ofmap_valid;
    logic                       ofmap_ready;

    modport master (
        output ren_wb, radr_wb, ofmap_data, ofmap_valid,
        input  rdata_wb, ofmap_ready
    );

    modport slave (
        input  ren_wb, radr_wb, ofmap_data, ofmap_valid,
        output rdata_wb, ofmap_ready
    );
endinterface

// File: rtl/accum_writeback_drain.sv
// Drains num_words accumulation words from the write-back port onto the ofmap
// stream through a 2-entry FIFO, issuing reads only when a slot is guaranteed.
module accum_writeback_drain #(
    parameter int DATA_WIDTH      = 64,
    parameter int BANK_ADDR_WIDTH = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [BANK_ADDR_WIDTH:0] num_words,
    output logic                     busy,
    output logic                     done,
    accum_writeback_drain_if.master  wb
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]                      state_q, state_d;
    logic [BANK_ADDR_WIDTH:0]        num_q, num_d;
    logic [BANK_ADDR_WIDTH:0]        addr_q, addr_d;
    logic                            pend_q, pend_d;
    logic [1:0][DATA_WIDTH-1:0]      mem_q, mem_d;
    logic                            rd_ptr_q, rd_ptr_d;
    logic                            wr_ptr_q, wr_ptr_d;
    logic [1:0]                      count_q, count_d;

    logic       pop;
    logic       push;
    logic       ren;
    logic [1:0] occ;

    always_comb begin
        pop  = (count_q != 2'd0) && wb.ofmap_ready;
        push = pend_q;
        // Occupancy counts data still in flight so a read never lands on a full FIFO.
        occ  = count_q + {1'b0, pend_q};
        ren  = (state_q == S_READ) && ((occ - {1'b0, pop}) < 2'd2);

        state_d  = state_q;
        num_d    = num_q;
        addr_d   = addr_q;
        pend_d   = ren;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};

        if (push) begin
            mem_d[wr_ptr_q] = wb.rdata_wb;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d   = num_words;
                    addr_d  = '0;
                    state_d = (num_words == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (ren) begin
                    addr_d = addr_q + 1'b1;
                    if (addr_q == num_q - 1'b1) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Last word leaves when the only entry pops with nothing in flight.
                if (pop && (count_q == 2'd1) && !pend_q) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            num_q    <= '0;
            addr_q   <= '0;
            pend_q   <= 1'b0;
            mem_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            addr_q   <= addr_d;
            pend_q   <= pend_d;
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wb.ren_wb      = ren;
    assign wb.radr_wb     = ren ? addr_q[BANK_ADDR_WIDTH-1:0] : '0;
    assign wb.ofmap_data  = mem_q[rd_ptr_q];
    assign wb.ofmap_valid = (count_q != 2'd0);
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
endmodule
